// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter for three cache controllers: round-robin grant, address
// broadcast, snoop-response collection, then memory read or owner write-back.
module snoop_bus_arbiter #(
    parameter int SNOOP_TIMEOUT = 8,
    parameter int MEM_TIMEOUT   = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] req_wr,
    input  logic [2:0] snoop_ack,
    input  logic [2:0] snoop_hit_m,
    input  logic       mem_done,
    output logic [2:0] grant,
    output logic       snoop_valid,
    output logic [1:0] snoop_src,
    output logic       snoop_op,
    output logic       abort_mem_accs,
    output logic [1:0] wb_sel,
    output logic       mem_start,
    output logic [2:0] done,
    output logic       busy,
    output logic       err,
    output logic [2:0] dbg_state
);

    // Handshake: req is a level held until the one-cycle done pulse; snoop_ack
    // qualifies snoop_hit_m in the same cycle; mem_done is a one-cycle completion.

    localparam int CNT_MAX = (SNOOP_TIMEOUT > MEM_TIMEOUT) ? SNOOP_TIMEOUT : MEM_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_SNOOP = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    sel_q, sel_d;
    logic          op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ack_q, ack_d;
    logic [2:0]    hit_q, hit_d;
    logic          err_q, err_d;

    logic [2:0]    idx_oh;
    logic [2:0]    others;
    logic [2:0]    ack_all;
    logic [2:0]    hit_all;

    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] c;
        logic [1:0] pick;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        c     = (last == 2'd2) ? 2'd0 : last + 2'd1;
        for (int k = 0; k < 3; k++) begin
            if (!found && r[c]) begin
                pick  = c;
                found = 1'b1;
            end
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
        end
        return pick;
    endfunction

    function automatic logic [1:0] lowest_set(input logic [2:0] v);
        logic [1:0] r;
        r = 2'd0;
        if (v[2]) r = 2'd2;
        if (v[1]) r = 2'd1;
        if (v[0]) r = 2'd0;
        return r;
    endfunction

    assign idx_oh  = 3'b001 << idx_q;
    assign others  = ~idx_oh;
    // The granted cpu never snoops its own request.
    assign ack_all = (ack_q | snoop_ack) & others;
    assign hit_all = (hit_q | (snoop_ack & snoop_hit_m)) & others;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd2;
            sel_q   <= 2'd0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= 3'b000;
            hit_q   <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        sel_d   = sel_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        hit_d   = hit_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    idx_d   = rr_pick(req, last_q);
                    op_d    = req_wr[idx_d];
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                ack_d   = 3'b000;
                hit_d   = 3'b000;
                cnt_d   = '0;
                state_d = S_SNOOP;
            end
            S_SNOOP: begin
                ack_d = ack_all;
                hit_d = hit_all;
                if (ack_all == others) begin
                    cnt_d = '0;
                    if (|hit_all) begin
                        sel_d   = lowest_set(hit_all);
                        state_d = S_WB;
                    end else begin
                        state_d = S_MEM;
                    end
                end else if (cnt_q == CW'(SNOOP_TIMEOUT - 1)) begin
                    // Missing snoopers are treated as clean: memory supplies the block.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_MEM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MEM, S_WB: begin
                if (mem_done) begin
                    state_d = S_DONE;
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                last_d  = idx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy           = (state_q != S_IDLE);
    assign grant          = busy ? idx_oh : 3'b000;
    assign snoop_valid    = (state_q == S_ADDR);
    assign snoop_src      = busy ? idx_q : 2'd0;
    assign snoop_op       = busy & op_q;
    assign abort_mem_accs = (state_q == S_WB);
    assign wb_sel         = (state_q == S_WB) ? sel_q : 2'd0;
    assign mem_start      = (state_q == S_MEM) && (cnt_q == '0);
    assign done           = (state_q == S_DONE) ? idx_oh : 3'b000;
    assign err            = err_q;
    assign dbg_state      = state_q;

endmodule
